// File: rtl/apb_script_pkg.sv
// Shared opcodes, state encoding and field widths
// for the APB script master.
package apb_script_pkg;

    localparam int OP_W  = 3;
    localparam int ERR_W = 8;
    localparam int GAP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
    localparam logic [OP_W-1:0] OP_WRITE = 3'd1;
    localparam logic [OP_W-1:0] OP_READ  = 3'd2;
    localparam logic [OP_W-1:0] OP_POLL  = 3'd3;
    localparam logic [OP_W-1:0] OP_WAIT  = 3'd4;
    localparam logic [OP_W-1:0] OP_END   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_WAIT   = 3'd4,
        S_GAP    = 3'd5,
        S_FIN    = 3'd6
    } state_t;

endpackage

// File: rtl/apb_script_master_if.sv
// APB bus bundle between the script master
// and any APB slave.
interface apb_script_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_script_master.sv
// Command-table driven APB master: write, read-check,
// poll with timeout, wait and end.
module apb_script_master
    import apb_script_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 64,
    parameter int POLL_MAX = 1000,
    parameter int GAP_CYC  = 1,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    output logic [IDX_W-1:0]  CMD_IDX,
    input  logic [OP_W-1:0]   CMD_OP,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_DATA,
    input  logic [DATA_W-1:0] CMD_MASK,
    apb_script_master_if.master apb,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAIL,
    output logic [ERR_W-1:0]  ERR_CNT,
    output logic [DATA_W-1:0] RD_LAST
);
    localparam int PC_W = $clog2(POLL_MAX + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [PC_W-1:0]  POLL_END = PC_W'(POLL_MAX - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYC - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q, mask_q, wait_q, rd_q;
    logic [PC_W-1:0]   poll_q;
    logic [GAP_W-1:0]  gap_q;
    logic              retry_q, done_q, fail_q;
    logic [ERR_W-1:0]  err_q;

    logic is_nop, is_xfer, is_wait, is_end, wait0, last_idx;
    logic xfer_done, match, retry, err_ev, adv, start_ok;

    always_comb begin
        is_nop  = 1'b0;
        is_xfer = 1'b0;
        is_wait = 1'b0;
        is_end  = 1'b0;
        unique case (CMD_OP)
            OP_WRITE, OP_READ, OP_POLL: is_xfer = 1'b1;
            OP_WAIT: is_wait = 1'b1;
            OP_END:  is_end  = 1'b1;
            default: is_nop  = 1'b1;
        endcase
    end

    assign wait0     = is_wait && (CMD_DATA == '0);
    assign last_idx  = (idx_q == IDX_LAST);
    assign start_ok  = START && (state_q == S_IDLE || state_q == S_FIN);
    assign xfer_done = (state_q == S_ACCESS) && apb.PREADY;
    assign match     = ((apb.PRDATA ^ data_q) & mask_q) == '0;

    // A slave error ends a poll at once rather than retrying it.
    assign retry = xfer_done && (op_q == OP_POLL) && !apb.PSLVERR
                && !match && (poll_q != POLL_END);
    assign err_ev = xfer_done && (apb.PSLVERR || (!match
                 && ((op_q == OP_READ)
                 || (op_q == OP_POLL && poll_q == POLL_END))));
    assign adv = ((state_q == S_FETCH) && (is_nop || wait0))
              || ((state_q == S_WAIT) && (wait_q == DATA_W'(1)))
              || (xfer_done && !retry);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_FIN: if (START) state_d = S_FETCH;
            S_FETCH: begin
                unique case (1'b1)
                    is_end:              state_d = S_FIN;
                    is_xfer:             state_d = S_SETUP;
                    (is_wait && !wait0): state_d = S_WAIT;
                    default: state_d = last_idx ? S_FIN : S_FETCH;
                endcase
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (xfer_done) begin
                    if (adv && last_idx) state_d = S_FIN;
                    else if (GAP_CYC != 0) state_d = S_GAP;
                    else state_d = retry ? S_SETUP : S_FETCH;
                end
            end
            S_WAIT: begin
                if (wait_q == DATA_W'(1))
                    state_d = last_idx ? S_FIN : S_FETCH;
            end
            S_GAP: begin
                if (gap_q == '0)
                    state_d = retry_q ? S_SETUP : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            idx_q   <= '0;
            op_q    <= OP_NOP;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            wait_q  <= '0;
            rd_q    <= '0;
            poll_q  <= '0;
            gap_q   <= '0;
            retry_q <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            if (start_ok) begin
                idx_q  <= '0;
                done_q <= 1'b0;
                fail_q <= 1'b0;
                err_q  <= '0;
            end
            if (state_q == S_FETCH && is_xfer) begin
                op_q   <= CMD_OP;
                addr_q <= CMD_ADDR;
                data_q <= CMD_DATA;
                mask_q <= CMD_MASK;
                poll_q <= '0;
            end
            if (state_q == S_FETCH && is_wait) wait_q <= CMD_DATA;
            if (state_q == S_WAIT) wait_q <= wait_q - 1'b1;
            if (state_q == S_GAP) gap_q <= gap_q - 1'b1;
            if (xfer_done) begin
                if (op_q != OP_WRITE) rd_q <= apb.PRDATA;
                poll_q  <= retry ? poll_q + 1'b1 : '0;
                retry_q <= retry;
                gap_q   <= GAP_INIT;
            end
            // Index holds at the last entry so CMD_IDX shows where it ended.
            if (adv && !last_idx) idx_q <= idx_q + 1'b1;
            if (state_d == S_FIN && state_q != S_FIN) done_q <= 1'b1;
            if (err_ev) begin
                fail_q <= 1'b1;
                if (err_q != '1) err_q <= err_q + 1'b1;
            end
        end
    end

    always_comb begin
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        BUSY        = 1'b1;
        unique case (state_q)
            S_SETUP: begin
                apb.PSEL   = 1'b1;
                apb.PWRITE = (op_q == OP_WRITE);
            end
            S_ACCESS: begin
                apb.PSEL    = 1'b1;
                apb.PENABLE = 1'b1;
                apb.PWRITE  = (op_q == OP_WRITE);
            end
            S_IDLE, S_FIN: BUSY = 1'b0;
            default: ;
        endcase
    end

    assign apb.PADDR  = addr_q;
    assign apb.PWDATA = data_q;
    assign CMD_IDX    = idx_q;
    assign DONE       = done_q;
    assign FAIL       = fail_q;
    assign ERR_CNT    = err_q;
    assign RD_LAST    = rd_q;

endmodule
